// File: rtl/fifo_pkg.sv
// Shared constants and types for the async FIFO write-domain blocks.
package fifo_pkg;

    localparam int unsigned DefDsize = 32;
    localparam int unsigned DefAsize = 4;
    localparam int unsigned DefLvlW  = DefAsize + 1;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } ingress_state_e;

    // Occupancy needs one bit beyond the address so that a full FIFO reads as 2**asize.
    function automatic int unsigned lvl_width(input int unsigned asize);
        return asize + 1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: main register feeds the output, skid catches one extra word.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DefDsize
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [DSIZE-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [DSIZE-1:0] out_data_o,
    input  logic             out_pop_i
);

    ingress_state_e   state_q;
    logic [DSIZE-1:0] main_q;
    logic [DSIZE-1:0] skid_q;
    logic             ready_q;
    logic             accept;
    logic             pop;

    assign accept = in_valid_i & ready_q;
    assign pop    = out_pop_i & (state_q != StEmpty);

    // ready_q tracks "next state is not StTwo" so s_ready has no path from s_valid or wfull.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q <= StOne;
                        main_q  <= in_data_i;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        main_q <= in_data_i;
                    end else if (accept) begin
                        state_q <= StTwo;
                        skid_q  <= in_data_i;
                        ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        state_q <= StOne;
                        main_q  <= skid_q;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                end
            endcase
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = main_q;

endmodule

// File: rtl/fifo_wr_ingress.sv
// Write-domain front end: skid-buffers producer words, issues writes, tracks fill level.
module fifo_wr_ingress
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE        = DefDsize,
    parameter int unsigned ASIZE        = DefAsize,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             s_valid_i,
    input  logic [DSIZE-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             w_en_o,
    output logic [DSIZE-1:0] wdata_o,
    input  logic             wfull_i,
    input  logic [ASIZE:0]   wptr_i,
    input  logic [ASIZE:0]   wsync_rptr_i,
    output logic [ASIZE:0]   wlevel_o,
    output logic             walmost_full_o,
    output logic [15:0]      wr_count_o
);

    localparam int unsigned LvlW = lvl_width(ASIZE);
    localparam logic [LvlW-1:0] AfullThresh = LvlW'(AFULL_THRESH);

    logic            out_valid;
    logic            w_en;
    logic [LvlW-1:0] diff;
    logic [LvlW-1:0] wlevel_q;
    logic            walmost_full_q;
    logic [15:0]     wr_count_q;

    fifo_skid_buf #(
        .DSIZE(DSIZE)
    ) u_skid (
        .clk_i      (wclk),
        .rst_ni     (wrst_n),
        .in_valid_i (s_valid_i),
        .in_data_i  (s_data_i),
        .in_ready_o (s_ready_o),
        .out_valid_o(out_valid),
        .out_data_o (wdata_o),
        .out_pop_i  (w_en)
    );

    assign w_en = out_valid & ~wfull_i;

    // Modular subtraction handles wrap across the pointer MSB.
    assign diff = wptr_i - wsync_rptr_i;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel_q       <= '0;
            walmost_full_q <= 1'b0;
            wr_count_q     <= '0;
        end else begin
            wlevel_q       <= diff;
            walmost_full_q <= (diff >= AfullThresh);
            if (w_en) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign w_en_o         = w_en;
    assign wlevel_o       = wlevel_q;
    assign walmost_full_o = walmost_full_q;
    assign wr_count_o     = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_ingress.sv
// Scoreboard bench for fifo_wr_ingress with a queue-based model of the ingress buffer.
module tb_fifo_wr_ingress;

    logic        wclk;
    logic        wrst_n;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        w_en;
    logic [31:0] wdata;
    logic        wfull;
    logic [4:0]  wptr;
    logic [4:0]  rptr;
    logic [4:0]  wlevel;
    logic        walmost_full;
    logic [15:0] wr_count;

    int total = 0;
    int bad   = 0;

    // Reference model: words accepted but not yet written, in acceptance order.
    logic [31:0] exp_q[$];
    bit          ready_exp = 0;
    logic [15:0] n_wr      = 0;
    int          lev_exp   = 0;

    fifo_wr_ingress #(
        .DSIZE       (32),
        .ASIZE       (4),
        .AFULL_THRESH(12)
    ) dut (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .s_valid_i     (s_valid),
        .s_data_i      (s_data),
        .s_ready_o     (s_ready),
        .w_en_o        (w_en),
        .wdata_o       (wdata),
        .wfull_i       (wfull),
        .wptr_i        (wptr),
        .wsync_rptr_i  (rptr),
        .wlevel_o      (wlevel),
        .walmost_full_o(walmost_full),
        .wr_count_o    (wr_count)
    );

    initial wclk = 0;
    always #5 wclk = ~wclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge wrst_n) begin
        exp_q.delete();
        ready_exp = 0;
        n_wr      = 0;
        lev_exp   = 0;
    end

    // Model update on the active edge, using pre-edge inputs.
    always @(posedge wclk) begin
        if (wrst_n) begin
            bit do_pop;
            do_pop = (exp_q.size() > 0) && !wfull;
            if (s_valid && ready_exp) exp_q.push_back(s_data);
            if (do_pop) begin
                void'(exp_q.pop_front());
                n_wr = n_wr + 16'd1;
            end
            ready_exp = (exp_q.size() < 2);
            lev_exp   = (int'(wptr) - int'(rptr) + 32) % 32;
        end
    end

    // Monitor: compare DUT outputs away from the active edge.
    always @(negedge wclk) begin
        bit exp_wen;
        exp_wen = wrst_n && (exp_q.size() > 0) && !wfull;
        chk("w_en", 64'(w_en), 64'(exp_wen));
        if (exp_wen && w_en) chk("wdata", 64'(wdata), 64'(exp_q[0]));
        if (!wrst_n) chk("wdata_rst", 64'(wdata), 64'd0);
        chk("s_ready", 64'(s_ready), 64'(ready_exp));
        chk("wr_count", 64'(wr_count), 64'(n_wr));
        chk("wlevel", 64'(wlevel), 64'(lev_exp));
        chk("walmost_full", 64'(walmost_full), 64'(lev_exp >= 12));
    end

    task automatic step();
        @(posedge wclk);
        #2;
    endtask

    // mode: 0 wfull low, 1 toggle, 2 random, 3 high during cycles 2..7
    task automatic stream(input int n, input int mode, input logic [31:0] base,
                          input bit rnd_data, input int vprob);
        int  sent = 0;
        int  cyc  = 0;
        bit  acc;
        s_valid = 0;
        while (sent < n) begin
            if (!s_valid && (int'($urandom % 100) < vprob)) begin
                s_valid = 1;
                s_data  = rnd_data ? $urandom : base + 32'(sent);
            end
            case (mode)
                0:       wfull = 0;
                1:       wfull = cyc[0];
                2:       wfull = ($urandom % 4) == 0;
                default: wfull = (cyc >= 2) && (cyc < 8);
            endcase
            wptr = 5'($urandom);
            rptr = 5'($urandom);
            @(posedge wclk);
            acc = s_valid && s_ready;
            #2;
            cyc++;
            if (acc) begin
                sent++;
                s_valid = 0;
            end
            if (cyc > n * 8 + 50) begin
                chk("stream_timeout", 64'(sent), 64'(n));
                break;
            end
        end
        s_valid = 0;
    endtask

    task automatic drain();
        s_valid = 0;
        wfull   = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (exp_q.size() == 0) break;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        wrst_n = 0;
        step();
        step();
        wrst_n = 1;
        step();
    endtask

    initial begin
        s_valid = 0;
        s_data  = 0;
        wfull   = 0;
        wptr    = 0;
        rptr    = 0;
        wrst_n  = 1;
        #1 wrst_n = 0;
        #2;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_w_en", 64'(w_en), 64'd0);
        step();
        step();
        wrst_n = 1;
        step();
        chk("ready_after_rst", 64'(s_ready), 64'd1);

        stream(8, 0, 32'h1, 0, 100);
        drain();
        chk("count_8", 64'(wr_count), 64'd8);

        stream(10, 3, 32'h100, 0, 100);
        drain();

        stream(32, 1, 32'h200, 0, 100);
        drain();

        stream(300, 2, 32'h0, 1, 60);
        drain();

        wptr = 5'b10011;
        rptr = 5'b00111;
        step();
        chk("lvl12", 64'(wlevel), 64'd12);
        chk("af12", 64'(walmost_full), 64'd1);
        rptr = 5'b01000;
        step();
        chk("lvl11", 64'(wlevel), 64'd11);
        chk("af11", 64'(walmost_full), 64'd0);
        wptr = 5'b00010;
        rptr = 5'b11110;
        step();
        chk("lvl_wrap", 64'(wlevel), 64'd4);

        // Fill to two entries under wfull, then reset mid-cycle.
        wfull   = 1;
        s_valid = 1;
        s_data  = 32'hA00;
        for (int i = 0; i < 10; i++) begin
            bit acc;
            @(posedge wclk);
            acc = s_valid && s_ready;
            #2;
            if (acc) s_data = s_data + 32'd1;
            if (!s_ready) break;
        end
        chk("two_full", 64'(s_ready), 64'd0);
        #1 wrst_n = 0;
        #1;
        chk("mid_rst_w_en", 64'(w_en), 64'd0);
        chk("mid_rst_wdata", 64'(wdata), 64'd0);
        chk("mid_rst_ready", 64'(s_ready), 64'd0);
        chk("mid_rst_level", 64'(wlevel), 64'd0);
        s_valid = 0;
        wfull   = 0;
        step();
        step();
        wrst_n = 1;
        step();
        stream(4, 0, 32'hB00, 0, 100);
        drain();
        chk("post_rst_count", 64'(wr_count), 64'd4);

        do_reset();
        stream(65537, 0, 32'h0, 1, 100);
        drain();
        chk("count_wrap", 64'(wr_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
